cache_mem_arbiter: RTL and testbench

- Responder end of the cache-to-memory interface. Serves instruction-fetch requests (iREN/iaddr) and data requests (dREN/dWEN/daddr/dstore) from the L1 caches against a single-ported RAM.
- Arbitrates between the two caches, sequences each RAM access through a registered FSM, and returns iwait/dwait/iload/dload.
- Sits between the caches and the RAM model/controller.

---
 rtl/cache_mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Responder end of the cache-to-memory interface.
// Arbitrates icache fetches and dcache reads/writes onto one single-ported RAM,
// sequencing each access through a small registered FSM. State, grant history,
// the timeout counter and the sticky timeout flag are registered; all handshake
// and RAM-side outputs are decoded combinationally from state and live inputs.
module cache_mem_arbiter #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic              CLK,
  input  logic              nRST,
  // icache side
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  // dcache side
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  // RAM side
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  // status
  output logic              mem_timeout
);

  localparam logic [1:0] RAM_FREE   = 2'd0;
  localparam logic [1:0] RAM_BUSY   = 2'd1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  // Last counter value that may still wait; the next non-ACCESS cycle abandons.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DREAD  = 2'd2,
    DWRITE = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  state_t           state, state_next;
  grant_t           last_grant, last_grant_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             timeout_set;

  logic             d_rd_req;
  logic             d_wr_req;
  logic             d_req;
  logic             req;
  logic             done;

  // Write beats read when the dcache (illegally) raises both.
  assign d_wr_req = dWEN;
  assign d_rd_req = dREN & ~dWEN;
  assign d_req    = dWEN | dREN;

  // State, grant history, timeout counter and sticky timeout flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      last_grant  <= GRANT_I;
      cnt         <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      cnt        <= cnt_next;
      if (timeout_set) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  // Next-state, arbitration, timeout and combinational handshake/RAM outputs.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    cnt_next        = cnt;
    timeout_set     = 1'b0;
    req             = 1'b0;
    done            = 1'b0;
    iwait           = 1'b1;
    dwait           = 1'b1;
    iload           = '0;
    dload           = '0;
    ramREN          = 1'b0;
    ramWEN          = 1'b0;
    ramaddr         = '0;
    ramstore        = '0;

    // Request still held by the cache that owns the current access.
    case (state)
      IFETCH:  req = iREN;
      DREAD:   req = d_rd_req;
      DWRITE:  req = d_wr_req;
      default: req = 1'b0;
    endcase

    if (state == IDLE) begin
      // Data wins unless the data side was served last and a fetch is waiting.
      cnt_next = '0;
      if (iREN && (last_grant == GRANT_D || !d_req)) begin
        state_next = IFETCH;
      end else if (d_wr_req) begin
        state_next = DWRITE;
      end else if (d_rd_req) begin
        state_next = DREAD;
      end
    end else if (!req) begin
      // Withdrawn mid-access: enables already low, fall back to IDLE.
      state_next = IDLE;
    end else begin
      case (ramstate)
        RAM_ACCESS: begin
          done       = 1'b1;
          state_next = IDLE;
        end
        RAM_ERROR: begin
          state_next = IDLE;
        end
        RAM_FREE, RAM_BUSY: begin
          if (cnt == CNT_LAST) begin
            timeout_set = 1'b1;
            state_next  = IDLE;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // RAM enables and completion handshake for the granted cache.
    if (req) begin
      case (state)
        IFETCH: begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (done) begin
            iwait           = 1'b0;
            iload           = ramload;
            last_grant_next = GRANT_I;
          end
        end
        DREAD: begin
          ramREN  = 1'b1;
          ramaddr = daddr;
          if (done) begin
            dwait           = 1'b0;
            dload           = ramload;
            last_grant_next = GRANT_D;
          end
        end
        DWRITE: begin
          ramWEN   = 1'b1;
          ramaddr  = daddr;
          ramstore = dstore;
          if (done) begin
            dwait           = 1'b0;
            last_grant_next = GRANT_D;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: fetch, write, timeout, error/withdraw,
// async reset and round-robin contention, all with hand-computed expectations.
module tb_cache_mem_arbiter;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned CNT_W   = 7;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic              CLK;
  logic              nRST;
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic [1:0]        ramstate;
  logic              mem_timeout;

  int n_checks;
  int n_pass;

  cache_mem_arbiter #(
    .WORD_W (WORD_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .dREN       (dREN),
    .dWEN       (dWEN),
    .daddr      (daddr),
    .dstore     (dstore),
    .dwait      (dwait),
    .dload      (dload),
    .ramREN     (ramREN),
    .ramWEN     (ramWEN),
    .ramaddr    (ramaddr),
    .ramstore   (ramstore),
    .ramload    (ramload),
    .ramstate   (ramstate),
    .mem_timeout(mem_timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count one comparison and report a mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Both waits high and no RAM enables: the IDLE signature.
  task automatic check_idle(input string tag);
    check({tag, "_iwait"},  32'(iwait),  32'd1);
    check({tag, "_dwait"},  32'(dwait),  32'd1);
    check({tag, "_ramREN"}, 32'(ramREN), 32'd0);
    check({tag, "_ramWEN"}, 32'(ramWEN), 32'd0);
  endtask

  int        n_iwait_low;
  int        n_ren_high;
  int        n_back_to_back;
  logic      prev_low;
  logic      cur_low;
  logic      grant_d;
  logic [31:0] exp_load;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    nRST     = 1'b0;
    iREN     = 1'b0;
    iaddr    = '0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    ramload  = '0;
    ramstate = FREE;

    // Reset values
    #2;
    check_idle("rst");
    check("rst_ramaddr",  ramaddr,  32'h0);
    check("rst_ramstore", ramstore, 32'h0);
    check("rst_iload",    iload,    32'h0);
    check("rst_dload",    dload,    32'h0);
    check("rst_timeout",  32'(mem_timeout), 32'd0);
    cyc();
    nRST = 1'b1;
    cyc();

    // Single fetch: ACCESS on the second serving cycle
    iREN = 1'b1; iaddr = 32'h40; ramstate = FREE;
    #2; check_idle("f0");
    cyc();
    ramstate = BUSY;
    #2;
    check("f1_ramREN",  32'(ramREN), 32'd1);
    check("f1_ramaddr", ramaddr,     32'h40);
    check("f1_iwait",   32'(iwait),  32'd1);
    cyc();
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    #2;
    check("f2_iwait", 32'(iwait), 32'd0);
    check("f2_iload", iload,      32'hDEADBEEF);
    check("f2_dwait", 32'(dwait), 32'd1);
    cyc();
    iREN = 1'b0; ramstate = FREE;
    #2; check_idle("f3");
    cyc();

    // Write with immediate ACCESS
    dWEN = 1'b1; daddr = 32'h80; dstore = 32'h12345678;
    #2; check_idle("w0");
    cyc();
    ramstate = ACCESS;
    #2;
    check("w1_ramWEN",   32'(ramWEN), 32'd1);
    check("w1_ramREN",   32'(ramREN), 32'd0);
    check("w1_ramaddr",  ramaddr,     32'h80);
    check("w1_ramstore", ramstore,    32'h12345678);
    check("w1_dwait",    32'(dwait),  32'd0);
    check("w1_iwait",    32'(iwait),  32'd1);
    cyc();
    dWEN = 1'b0; ramstate = FREE;
    #2; check_idle("w2");
    cyc();

    // Timeout: RAM stuck BUSY for the whole serving window
    iREN = 1'b1; iaddr = 32'h100; ramstate = BUSY;
    #2; check_idle("t0");
    n_iwait_low = 0;
    n_ren_high  = 0;
    for (int k = 1; k <= int'(TIMEOUT); k++) begin
      cyc();
      #2;
      if (!iwait) n_iwait_low++;
      if (ramREN) n_ren_high++;
    end
    check("t_iwait_lows",    32'(n_iwait_low), 32'd0);
    check("t_ren_cycles",    32'(n_ren_high),  32'(TIMEOUT));
    check("t_flag_before",   32'(mem_timeout), 32'd0);
    cyc();
    #2;
    check_idle("t_idle");
    check("t_flag_set", 32'(mem_timeout), 32'd1);
    cyc();
    ramstate = ACCESS; ramload = 32'hCAFEF00D;
    #2;
    check("t_retry_iwait", 32'(iwait), 32'd0);
    check("t_retry_iload", iload,      32'hCAFEF00D);
    cyc();
    iREN = 1'b0; ramstate = FREE;
    #2;
    check_idle("t_after");
    check("t_flag_sticky", 32'(mem_timeout), 32'd1);
    cyc();

    // ERROR retries the read, then the dcache withdraws before ACCESS
    dREN = 1'b1; daddr = 32'h200;
    #2; check_idle("e0");
    cyc();
    ramstate = ERROR;
    #2;
    check("e1_ramREN", 32'(ramREN), 32'd1);
    check("e1_dwait",  32'(dwait),  32'd1);
    cyc();
    ramstate = FREE;
    #2; check_idle("e2");
    cyc();
    ramstate = BUSY;
    #2;
    check("e3_ramREN",  32'(ramREN), 32'd1);
    check("e3_ramaddr", ramaddr,     32'h200);
    #1;
    dREN = 1'b0;
    #1;
    check("e3_withdraw_ren", 32'(ramREN), 32'd0);
    check("e3_withdraw_dw",  32'(dwait),  32'd1);
    cyc();
    dREN = 1'b1;
    #2; check_idle("e4");
    cyc();
    ramstate = ACCESS; ramload = 32'h0BADF00D;
    #2;
    check("e5_dwait", 32'(dwait), 32'd0);
    check("e5_dload", dload,      32'h0BADF00D);
    cyc();
    dREN = 1'b0; ramstate = FREE;
    #2; check_idle("e6");
    cyc();

    // Async reset in the middle of a fetch
    iREN = 1'b1; iaddr = 32'h44; ramstate = BUSY;
    cyc();
    #2;
    check("r_pre_ramREN", 32'(ramREN), 32'd1);
    #1;
    nRST = 1'b0;
    #1;
    check("r_iwait",   32'(iwait),       32'd1);
    check("r_ramREN",  32'(ramREN),      32'd0);
    check("r_timeout", 32'(mem_timeout), 32'd0);
    dREN = 1'b1; daddr = 32'h88; ramstate = ACCESS; ramload = 32'h11110000;
    cyc();
    nRST = 1'b1;
    #2; check_idle("r_idle");
    cyc();
    #2;
    check("r_first_dwait",   32'(dwait), 32'd0);
    check("r_first_iwait",   32'(iwait), 32'd1);
    check("r_first_ramaddr", ramaddr,    32'h88);

    // Contention: both held, grants alternate I, D, I, D with IDLE between
    n_back_to_back = 0;
    prev_low       = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      ramload = 32'hC0000000 + 32'(k);
      #2;
      cur_low = !iwait || !dwait;
      if (cur_low && prev_low) n_back_to_back++;
      prev_low = cur_low;
      if (k % 2 == 0) begin
        check($sformatf("c%0d_idle_ren", k), 32'(ramREN), 32'd0);
      end else begin
        grant_d  = ((k / 2) % 2) == 1;
        exp_load = 32'hC0000000 + 32'(k);
        check($sformatf("c%0d_iwait", k),   32'(iwait), grant_d ? 32'd1 : 32'd0);
        check($sformatf("c%0d_dwait", k),   32'(dwait), grant_d ? 32'd0 : 32'd1);
        check($sformatf("c%0d_ramaddr", k), ramaddr,    grant_d ? 32'h88 : 32'h44);
        check($sformatf("c%0d_load", k),    grant_d ? dload : iload, exp_load);
      end
    end
    check("c_back_to_back", 32'(n_back_to_back), 32'd0);
    iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
